// File: rtl/mcif_rd_rsp_router_pkg.sv
// Shared types and constants for the MCIF read-response router.
// Optional checker enabled by defining MCIF_RSP_CHK_EN.
package mcif_rd_rsp_router_pkg;

  localparam int MCIF_CLIENT_NUM = 2;
  localparam int MCIF_ID_W       = 1;

  typedef enum logic [MCIF_ID_W-1:0] {
    CLIENT0 = 1'b0,
    CLIENT1 = 1'b1
  } client_e;

  // Tag layout is {id, len}; len occupies the low bits.
  function automatic int tag_w(input int len_w);
    return MCIF_ID_W + len_w;
  endfunction

endpackage

// File: rtl/mcif_rd_rsp_router_tag_fifo.sv
// In-order tag FIFO holding {id,len} of every accepted read command.
// Push is ignored when full, pop is ignored when empty; no write-to-read bypass.
module mcif_tag_fifo #(
  parameter  int W     = 9,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mcif_rd_rsp_router.sv
// Steers MCIF read-response beats to the client that owns the head tag and generates per-burst last.
// Define MCIF_RSP_CHK_EN to add mem_rsp_last input and the sticky rsp_err protocol checker.
module mcif_rd_rsp_router
  import mcif_rd_rsp_router_pkg::*;
#(
  parameter  int DAT_W = 256,
  parameter  int LEN_W = 8,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_acc,
  input  logic [MCIF_ID_W-1:0] cmd_id,
  input  logic [LEN_W-1:0]     cmd_len,
  output logic                 cmd_stall,
  input  logic                 mem_rsp_vld,
  input  logic [DAT_W-1:0]     mem_rsp_dat,
  output logic                 mem_rsp_rdy,
  output logic                 c0_rsp_vld,
  output logic [DAT_W-1:0]     c0_rsp_dat,
  output logic                 c0_rsp_last,
  input  logic                 c0_rsp_rdy,
  output logic                 c1_rsp_vld,
  output logic [DAT_W-1:0]     c1_rsp_dat,
  output logic                 c1_rsp_last,
  input  logic                 c1_rsp_rdy,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 idle
`ifdef MCIF_RSP_CHK_EN
  ,
  input  logic                 mem_rsp_last,
  output logic                 rsp_err
`endif
);

  localparam int TAG_W = tag_w(LEN_W);

  logic [TAG_W-1:0] push_tag, head_tag;
  logic             fifo_full, fifo_empty;
  client_e          head_id;
  logic [LEN_W-1:0] head_len;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             beat_acc, beat_last, pop;

  assign push_tag = {cmd_id, cmd_len};

  mcif_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_acc),
    .wr_data (push_tag),
    .pop     (pop),
    .rd_data (head_tag),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding)
  );

  // Data is a plain fan-out; only the valid/last/ready handshake is steered.
  assign c0_rsp_dat = mem_rsp_dat;
  assign c1_rsp_dat = mem_rsp_dat;
  assign cmd_stall  = fifo_full;
  assign idle       = (outstanding == '0) && (cnt_q == '0);

  always_comb begin
    head_id     = client_e'(head_tag[TAG_W-1 -: MCIF_ID_W]);
    head_len    = head_tag[LEN_W-1:0];
    beat_last   = ~fifo_empty && (cnt_q == head_len);
    c0_rsp_vld  = 1'b0;
    c1_rsp_vld  = 1'b0;
    c0_rsp_last = 1'b0;
    c1_rsp_last = 1'b0;
    mem_rsp_rdy = 1'b0;
    if (!fifo_empty) begin
      if (head_id == CLIENT1) begin
        c1_rsp_vld  = mem_rsp_vld;
        c1_rsp_last = beat_last;
        mem_rsp_rdy = c1_rsp_rdy;
      end else begin
        c0_rsp_vld  = mem_rsp_vld;
        c0_rsp_last = beat_last;
        mem_rsp_rdy = c0_rsp_rdy;
      end
    end
    beat_acc = mem_rsp_vld & mem_rsp_rdy;
    pop      = beat_acc & beat_last;
    cnt_d    = cnt_q;
    if (pop)           cnt_d = '0;
    else if (beat_acc) cnt_d = cnt_q + LEN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

`ifdef MCIF_RSP_CHK_EN
  logic rsp_err_q, rsp_err_d;

  // Sticky: flags a last-beat disagreement with memory or a push attempted while full.
  always_comb begin
    rsp_err_d = rsp_err_q;
    if (beat_acc && (mem_rsp_last != beat_last)) rsp_err_d = 1'b1;
    if (cmd_acc && fifo_full)                    rsp_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_err_q <= 1'b0;
    else        rsp_err_q <= rsp_err_d;
  end

  assign rsp_err = rsp_err_q;
`endif

endmodule

// File: tb/tb_mcif_rd_rsp_router.sv
// Self-checking bench: directed scenarios plus randomized traffic against a burst-queue model.
module tb_mcif_rd_rsp_router;

  localparam int DAT_W = 256;
  localparam int LEN_W = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_acc;
  logic             cmd_id;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_stall;
  logic             mem_rsp_vld;
  logic [DAT_W-1:0] mem_rsp_dat;
  logic             mem_rsp_rdy;
  logic             c0_rsp_vld, c0_rsp_last, c0_rsp_rdy;
  logic             c1_rsp_vld, c1_rsp_last, c1_rsp_rdy;
  logic [DAT_W-1:0] c0_rsp_dat, c1_rsp_dat;
  logic [CNT_W-1:0] outstanding;
  logic             idle;
`ifdef MCIF_RSP_CHK_EN
  logic             mem_rsp_last;
  logic             rsp_err;
`endif

  mcif_rd_rsp_router #(.DAT_W(DAT_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_acc     (cmd_acc),
    .cmd_id      (cmd_id),
    .cmd_len     (cmd_len),
    .cmd_stall   (cmd_stall),
    .mem_rsp_vld (mem_rsp_vld),
    .mem_rsp_dat (mem_rsp_dat),
    .mem_rsp_rdy (mem_rsp_rdy),
    .c0_rsp_vld  (c0_rsp_vld),
    .c0_rsp_dat  (c0_rsp_dat),
    .c0_rsp_last (c0_rsp_last),
    .c0_rsp_rdy  (c0_rsp_rdy),
    .c1_rsp_vld  (c1_rsp_vld),
    .c1_rsp_dat  (c1_rsp_dat),
    .c1_rsp_last (c1_rsp_last),
    .c1_rsp_rdy  (c1_rsp_rdy),
    .outstanding (outstanding),
    .idle        (idle)
`ifdef MCIF_RSP_CHK_EN
    ,
    .mem_rsp_last(mem_rsp_last),
    .rsp_err     (rsp_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending bursts and beats already delivered for the head burst.
  int q_id[$];
  int q_len[$];
  int done_beats = 0;
  bit err_m = 1'b0;

  task automatic check(input string tag, input logic [DAT_W-1:0] got, input logic [DAT_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DAT_W-1:0] rand_dat();
    logic [DAT_W-1:0] d;
    for (int i = 0; i < DAT_W / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // One clock: drive at negedge, check combinational outputs 1 ns later, advance model and clock.
  task automatic step(input bit acc, input bit id, input int len, input bit vld,
                      input bit r0, input bit r1, input bit bad_last);
    bit e_rdy, e_v0, e_v1, e_last, acc_beat;
    int h, sz;
    cmd_acc     = acc;
    cmd_id      = id;
    cmd_len     = LEN_W'(len);
    mem_rsp_vld = vld;
    mem_rsp_dat = rand_dat();
    c0_rsp_rdy  = r0;
    c1_rsp_rdy  = r1;
    sz     = q_id.size();
    e_rdy  = 1'b0;
    e_v0   = 1'b0;
    e_v1   = 1'b0;
    e_last = 1'b0;
    h      = 0;
    if (sz > 0) begin
      h      = q_id[0];
      e_last = (done_beats == q_len[0]);
      if (h == 1) begin e_v1 = vld; e_rdy = r1; end
      else        begin e_v0 = vld; e_rdy = r0; end
    end
`ifdef MCIF_RSP_CHK_EN
    mem_rsp_last = e_last ^ bad_last;
`endif
    #1;
    check("mem_rsp_rdy", DAT_W'(mem_rsp_rdy), DAT_W'(e_rdy));
    check("c0_rsp_vld",  DAT_W'(c0_rsp_vld),  DAT_W'(e_v0));
    check("c1_rsp_vld",  DAT_W'(c1_rsp_vld),  DAT_W'(e_v1));
    if (e_v0) begin
      check("c0_rsp_last", DAT_W'(c0_rsp_last), DAT_W'(e_last));
      check("c0_rsp_dat",  c0_rsp_dat, mem_rsp_dat);
    end
    if (e_v1) begin
      check("c1_rsp_last", DAT_W'(c1_rsp_last), DAT_W'(e_last));
      check("c1_rsp_dat",  c1_rsp_dat, mem_rsp_dat);
    end
    check("cmd_stall",   DAT_W'(cmd_stall),   DAT_W'(sz == DEPTH));
    check("outstanding", DAT_W'(outstanding), DAT_W'(sz));
    check("idle",        DAT_W'(idle),        DAT_W'(sz == 0 && done_beats == 0));
`ifdef MCIF_RSP_CHK_EN
    check("rsp_err", DAT_W'(rsp_err), DAT_W'(err_m));
`endif
    acc_beat = vld && e_rdy;
`ifdef MCIF_RSP_CHK_EN
    if (acc_beat && (e_last ^ bad_last) != e_last) err_m = 1'b1;
    if (acc && sz == DEPTH) err_m = 1'b1;
`endif
    if (acc_beat) begin
      if (e_last) begin
        void'(q_id.pop_front());
        void'(q_len.pop_front());
        done_beats = 0;
      end else begin
        done_beats++;
      end
    end
    if (acc && sz < DEPTH) begin
      q_id.push_back(int'(id));
      q_len.push_back(len);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    cmd_acc     = 1'b0;
    cmd_id      = 1'b0;
    cmd_len     = '0;
    mem_rsp_vld = 1'b1;
    mem_rsp_dat = rand_dat();
    c0_rsp_rdy  = 1'b1;
    c1_rsp_rdy  = 1'b1;
`ifdef MCIF_RSP_CHK_EN
    mem_rsp_last = 1'b0;
`endif
    q_id.delete();
    q_len.delete();
    done_beats = 0;
    err_m      = 1'b0;
    #1;
    check("rst_mem_rsp_rdy", DAT_W'(mem_rsp_rdy), '0);
    check("rst_c0_vld",      DAT_W'(c0_rsp_vld),  '0);
    check("rst_c1_vld",      DAT_W'(c1_rsp_vld),  '0);
    check("rst_c0_last",     DAT_W'(c0_rsp_last), '0);
    check("rst_c1_last",     DAT_W'(c1_rsp_last), '0);
    check("rst_stall",       DAT_W'(cmd_stall),   '0);
    check("rst_outstanding", DAT_W'(outstanding), '0);
    check("rst_idle",        DAT_W'(idle),        DAT_W'(1));
`ifdef MCIF_RSP_CHK_EN
    check("rst_rsp_err",     DAT_W'(rsp_err),     '0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q_id.size() > 0; i++) step(0, 0, 0, 1, 1, 1, 0);
    check("drain_empty", DAT_W'(q_id.size()), '0);
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Single id0 burst of four beats.
    step(1, 0, 3, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);

    // Back-to-back mixed-client bursts.
    step(1, 1, 0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 1, 1, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);

    // Fill to full, push into full, then push on the cycle of a pop-from-full and a normal push+pop.
    for (int i = 0; i < DEPTH; i++) step(1, i[0], 0, 0, 1, 1, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    step(1, 0, 2, 1, 1, 1, 0);
    step(1, 1, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    drain();

    // Client 0 back-pressure mid-burst.
    step(1, 0, 2, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);

    // Response valid with nothing outstanding is held off, then delivered after a push.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 1, 0);
    step(1, 1, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);

    // Wrong memory last on the second beat, then reset in the middle of that burst.
    step(1, 0, 3, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    do_reset();
    step(0, 0, 0, 1, 1, 1, 0);

    // Randomized traffic with occasional wrong last and rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) % 12 : $urandom_range(0, 3),
                $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75,
                $urandom_range(0, 99) < 75, $urandom_range(0, 199) == 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
